// File: rtl/rv_alu_md.sv
// rv_alu_md: RISC-V integer ALU with iterative multiply/divide.
// Single-cycle ALU ops plus XLEN-iteration shift-add multiply and restoring divide.
module rv_alu_md #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    localparam logic [SHW-1:0]  LAST = SHW'(XLEN - 1);
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    state_t              r_state, w_state_n;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opnd;
    logic [1:0]          r_sel;
    logic                r_neg;
    logic [SHW-1:0]      r_cnt;
    logic                r_valid;
    logic [XLEN-1:0]     r_result;

    logic                w_is_mul, w_is_div, w_sa, w_sb, w_an, w_bn, w_neg;
    logic                w_bz, w_ovf, w_accept, w_start_mul, w_start_div;
    logic [XLEN-1:0]     w_abs_a, w_abs_b, w_single;
    logic [XLEN:0]       w_msum, w_dsh, w_dsub;
    logic [2*XLEN-1:0]   w_mnext, w_dnext, w_prod;
    logic [XLEN-1:0]     w_mres, w_dres, w_q, w_r;

    assign ready_o  = (r_state == IDLE);
    assign valid_o  = r_valid;
    assign result_o = r_result;
    assign zero_o   = (r_result == '0);

    // Operand decode: signedness, magnitudes, result sign and division corners.
    always_comb begin
        w_is_mul    = (op_i[4:2] == 3'b100);
        w_is_div    = (op_i[4:2] == 3'b101);
        w_sa        = w_is_mul ? (op_i[1:0] != 2'b11) : ~op_i[0];
        w_sb        = w_is_mul ? ~op_i[1] : ~op_i[0];
        w_an        = w_sa & a_i[XLEN-1];
        w_bn        = w_sb & b_i[XLEN-1];
        w_abs_a     = w_an ? -a_i : a_i;
        w_abs_b     = w_bn ? -b_i : b_i;
        w_neg       = (w_is_div && op_i[1]) ? w_an : (w_an ^ w_bn);
        w_bz        = (b_i == '0);
        w_ovf       = ~op_i[0] && (a_i == MINV) && (b_i == '1);
        w_accept    = valid_i && ready_o && !flush_i;
        w_start_mul = w_accept && w_is_mul;
        w_start_div = w_accept && w_is_div && !w_bz && !w_ovf;
    end

    // Single-cycle result, including divide-by-zero and signed overflow.
    always_comb begin
        w_single = '0;
        case (op_i)
            5'd0:  w_single = a_i + b_i;
            5'd1:  w_single = a_i - b_i;
            5'd2:  w_single = a_i & b_i;
            5'd3:  w_single = a_i | b_i;
            5'd4:  w_single = a_i ^ b_i;
            5'd5:  w_single = a_i << b_i[SHW-1:0];
            5'd6:  w_single = a_i >> b_i[SHW-1:0];
            5'd7:  w_single = $signed(a_i) >>> b_i[SHW-1:0];
            5'd8:  w_single = XLEN'($signed(a_i) < $signed(b_i));
            5'd9:  w_single = XLEN'(a_i < b_i);
            5'd20, 5'd21, 5'd22, 5'd23: begin
                if (w_bz) w_single = op_i[1] ? a_i : '1;
                else      w_single = op_i[1] ? '0 : a_i;
            end
            default: w_single = '0;
        endcase
    end

    // One multiply step and one restoring-divide step on the accumulator.
    always_comb begin
        w_msum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                  (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_mnext = {w_msum, r_acc[XLEN-1:1]};
        w_prod  = r_neg ? -w_mnext : w_mnext;
        w_mres  = (r_sel == 2'b00) ? w_prod[XLEN-1:0]
                                   : w_prod[2*XLEN-1:XLEN];
        w_dsh   = r_acc[2*XLEN-1:XLEN-1];
        w_dsub  = w_dsh - {1'b0, r_opnd};
        w_dnext = w_dsub[XLEN] ?
                  {w_dsh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0} :
                  {w_dsub[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        w_q     = w_dnext[XLEN-1:0];
        w_r     = w_dnext[2*XLEN-1:XLEN];
        w_dres  = r_sel[1] ? (r_neg ? -w_r : w_r)
                           : (r_neg ? -w_q : w_q);
    end

    // Next-state logic; flush always returns to IDLE.
    always_comb begin
        w_state_n = r_state;
        if (flush_i) begin
            w_state_n = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_mul)      w_state_n = MUL;
                    else if (w_start_div) w_state_n = DIV;
                end
                MUL, DIV: begin
                    if (r_cnt == LAST) w_state_n = IDLE;
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_n;
    end

    // Datapath: operand latch, iteration, result and valid pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc    <= '0;
            r_opnd   <= '0;
            r_sel    <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
        end else begin
            r_valid <= 1'b0;
            if (!flush_i) begin
                case (r_state)
                    IDLE: begin
                        if (w_start_mul || w_start_div) begin
                            r_acc  <= {{XLEN{1'b0}},
                                       w_start_mul ? w_abs_b : w_abs_a};
                            r_opnd <= w_start_mul ? w_abs_a : w_abs_b;
                            r_sel  <= op_i[1:0];
                            r_neg  <= w_neg;
                            r_cnt  <= '0;
                        end else if (w_accept) begin
                            r_result <= w_single;
                            r_valid  <= 1'b1;
                        end
                    end
                    MUL: begin
                        r_acc <= w_mnext;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            r_result <= w_mres;
                            r_valid  <= 1'b1;
                        end
                    end
                    DIV: begin
                        r_acc <= w_dnext;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            r_result <= w_dres;
                            r_valid  <= 1'b1;
                        end
                    end
                    default: r_cnt <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rv_alu_md.sv
// tb_rv_alu_md: directed self-checking bench for rv_alu_md (XLEN=32).
// Each task drives one scenario and checks outputs on the falling edge.
module tb_rv_alu_md;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [4:0]  op_i = '0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        valid_o;
    logic [31:0] result_o;
    logic        zero_o;

    int n_cmp = 0;
    int n_bad = 0;

    rv_alu_md #(.XLEN(32)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush_i  (flush_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .valid_o  (valid_o),
        .result_o (result_o),
        .zero_o   (zero_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive one request for one cycle; returns at the falling edge
    // of the first cycle after the accepting edge.
    task automatic issue(input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        valid_i = 1'b1;
        op_i = op;
        a_i = a;
        b_i = b;
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    // Count cycles (from 1) until valid_o, and cycles with ready_o low.
    task automatic wait_valid(output int n, output int low);
        n = 1;
        low = 0;
        while (!valid_o && n < 100) begin
            if (!ready_o) low++;
            @(negedge clk_i);
            n++;
        end
        if (!valid_o) n = -1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (result_o !== 32'h0 || valid_o !== 1'b0 ||
            ready_o !== 1'b1 || zero_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset: res=%h v=%b rdy=%b z=%b required 0/0/1/1",
                     result_o, valid_o, ready_o, zero_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk_i);
        valid_i = 1'b1; op_i = 5'd0; a_i = 32'd7; b_i = 32'd5;
        @(negedge clk_i);
        n_cmp++;
        if (valid_o !== 1'b1 || result_o !== 32'd12) begin
            n_bad++;
            $display("FAIL b2b_add: v=%b res=%h required 1/0000000c",
                     valid_o, result_o);
        end
        op_i = 5'd1; a_i = 32'd5; b_i = 32'd5;
        @(negedge clk_i);
        n_cmp++;
        if (valid_o !== 1'b1 || result_o !== 32'd0 || zero_o !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_sub: v=%b res=%h z=%b required 1/0/1",
                     valid_o, result_o, zero_o);
        end
        op_i = 5'd7; a_i = 32'h8000_0000; b_i = 32'd4;
        @(negedge clk_i);
        valid_i = 1'b0;
        n_cmp++;
        if (valid_o !== 1'b1 || result_o !== 32'hF800_0000 || zero_o !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_sra: v=%b res=%h z=%b required 1/f8000000/0",
                     valid_o, result_o, zero_o);
        end
        @(negedge clk_i);
        n_cmp++;
        if (valid_o !== 1'b0 || result_o !== 32'hF800_0000) begin
            n_bad++;
            $display("FAIL b2b_hold: v=%b res=%h required 0/f8000000",
                     valid_o, result_o);
        end
    endtask

    task automatic test_alu();
        logic [4:0]  ops [10];
        logic [31:0] as  [10];
        logic [31:0] bs  [10];
        logic [31:0] exs [10];
        ops = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd8, 5'd10, 5'd31};
        as  = '{32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_F0F0, 32'd1,
                32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3,
                32'd9, 32'd9};
        bs  = '{32'h0000_FF00, 32'h0000_FF00, 32'h0000_FF00, 32'd33,
                32'd31, 32'd1, 32'd1, 32'hFFFF_FFFE, 32'd9, 32'd9};
        exs = '{32'h0000_F000, 32'h0000_FFF0, 32'h0000_0FF0, 32'd2,
                32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 10; i++) begin
            issue(ops[i], as[i], bs[i]);
            n_cmp++;
            if (valid_o !== 1'b1 || result_o !== exs[i]) begin
                n_bad++;
                $display("FAIL alu[%0d] op=%0d: v=%b res=%h required 1/%h",
                         i, ops[i], valid_o, result_o, exs[i]);
            end
        end
    endtask

    task automatic test_muldiv();
        logic [4:0]  ops [8];
        logic [31:0] as  [8];
        logic [31:0] bs  [8];
        logic [31:0] exs [8];
        int n, low;
        ops = '{5'd17, 5'd19, 5'd16, 5'd18, 5'd20, 5'd22, 5'd21, 5'd23};
        as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        bs  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                32'd2, 32'd2, 32'd7, 32'd7};
        exs = '{32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_valid(n, low);
            n_cmp++;
            if (n != 33 || low != 32 || result_o !== exs[i] || ready_o !== 1'b1) begin
                n_bad++;
                $display("FAIL md[%0d] op=%0d: cyc=%0d low=%0d res=%h rdy=%b required 33/32/%h/1",
                         i, ops[i], n, low, result_o, ready_o, exs[i]);
            end
        end
    endtask

    task automatic test_div_corner();
        logic [4:0]  ops [4];
        logic [31:0] as  [4];
        logic [31:0] bs  [4];
        logic [31:0] exs [4];
        ops = '{5'd20, 5'd23, 5'd20, 5'd22};
        as  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        bs  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        exs = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i]);
            n_cmp++;
            if (valid_o !== 1'b1 || ready_o !== 1'b1 || result_o !== exs[i]) begin
                n_bad++;
                $display("FAIL corner[%0d]: v=%b rdy=%b res=%h required 1/1/%h",
                         i, valid_o, ready_o, result_o, exs[i]);
            end
        end
    endtask

    task automatic test_flush();
        int pulses;
        issue(5'd0, 32'd40, 32'd2);
        issue(5'd21, 32'd100, 32'd7);
        repeat (9) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        n_cmp++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || result_o !== 32'd42) begin
            n_bad++;
            $display("FAIL flush: v=%b rdy=%b res=%h required 0/1/0000002a",
                     valid_o, ready_o, result_o);
        end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (valid_o) pulses++;
        end
        n_cmp++;
        if (pulses != 0 || result_o !== 32'd42) begin
            n_bad++;
            $display("FAIL flush_late: pulses=%0d res=%h required 0/0000002a",
                     pulses, result_o);
        end
        valid_i = 1'b1; op_i = 5'd0; a_i = 32'd1; b_i = 32'd1;
        flush_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (valid_o !== 1'b0 || result_o !== 32'd42) begin
            n_bad++;
            $display("FAIL flush_idle: v=%b res=%h required 0/0000002a",
                     valid_o, result_o);
        end
    endtask

    task automatic test_rst_abort();
        int pulses;
        issue(5'd21, 32'd100, 32'd7);
        repeat (9) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 ||
            result_o !== 32'd0 || zero_o !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_abort: v=%b rdy=%b res=%h z=%b required 0/1/0/1",
                     valid_o, ready_o, result_o, zero_o);
        end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (valid_o) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL rst_late: pulses=%0d required 0", pulses);
        end
    endtask

    task automatic test_stability();
        int n;
        issue(5'd16, 32'd3, 32'd4);
        n = 1;
        while (!valid_o && n < 100) begin
            op_i = 5'($urandom_range(0, 9));
            a_i = $urandom;
            b_i = $urandom;
            valid_i = (n < 30);
            @(negedge clk_i);
            n++;
        end
        valid_i = 1'b0;
        n_cmp++;
        if (n != 33 || result_o !== 32'd12) begin
            n_bad++;
            $display("FAIL stability: cyc=%0d res=%h required 33/0000000c",
                     n, result_o);
        end
        @(negedge clk_i);
        n_cmp++;
        if (valid_o !== 1'b0 || result_o !== 32'd12) begin
            n_bad++;
            $display("FAIL stability_hold: v=%b res=%h required 0/0000000c",
                     valid_o, result_o);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_alu();
        test_muldiv();
        test_div_corner();
        test_flush();
        test_rst_abort();
        test_stability();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
